// File: rtl/spi_pkg.sv
// Shared state encoding, mode type and signalling levels for the parametrised SPI master.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam logic SPI_READY     = 1'b1;
    localparam logic SPI_BUSY      = 1'b1;
    localparam logic SS_CONNECT    = 1'b0;
    localparam logic SS_DISCONNECT = 1'b1;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK timebase: half-period counter, tick, edge counter and leading/trailing strobes.
module spi_clk_gen #(
    parameter int   DATA_W   = 8,
    parameter int   DIV_W    = 8,
    parameter logic CPOL_RST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div_i,
    input  logic             cpol_i,
    input  logic             run_i,
    input  logic             restart_i,
    output logic             tick_o,
    output logic             lead_o,
    output logic             trail_o,
    output logic             last_o,
    output logic             sclk_o
);

    localparam int            EW    = $clog2(2 * DATA_W + 2);
    localparam logic [EW-1:0] EDGES = EW'(2 * DATA_W);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [EW-1:0]    edge_q, edge_d;
    logic             sclk_q, sclk_d;
    logic             in_shift;

    // Tick index 0 closes the setup half period; indices 1..2*DATA_W are real SCLK edges.
    assign tick_o   = run_i && (cnt_q == div_i);
    assign in_shift = (edge_q != '0) && (edge_q <= EDGES);
    assign lead_o   = tick_o && in_shift && edge_q[0];
    assign trail_o  = tick_o && in_shift && !edge_q[0];
    assign last_o   = tick_o && (edge_q == EDGES);
    assign sclk_o   = sclk_q;

    always_comb begin
        cnt_d  = cnt_q;
        edge_d = edge_q;
        sclk_d = sclk_q;
        if (restart_i) begin
            cnt_d  = '0;
            edge_d = '0;
            sclk_d = cpol_i;
        end else if (run_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
            if (tick_o && (edge_q <= EDGES)) edge_d = edge_q + 1'b1;
            if (lead_o || trail_o) sclk_d = ~sclk_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            edge_q <= '0;
            sclk_q <= CPOL_RST;
        end else begin
            cnt_q  <= cnt_d;
            edge_q <= edge_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: runtime mode/divider/bit order, multiple slave selects,
// valid/ready intake with back-to-back words that keep the slave selected.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int   DATA_W   = 8,
    parameter int   NUM_SS   = 4,
    parameter int   DIV_W    = 8,
    parameter logic CPOL_RST = 1'b0,
    localparam int  SEL_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic              cfg_lsb_first,
    input  logic [DIV_W-1:0]  cfg_clk_div,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SEL_W-1:0]  tx_ss_sel,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);

    function automatic logic [DATA_W-1:0] bitrev(input logic [DATA_W-1:0] v);
        for (int i = 0; i < DATA_W; i++) bitrev[i] = v[DATA_W-1-i];
    endfunction

    function automatic logic [NUM_SS-1:0] ss_decode(input logic [SEL_W-1:0] sel);
        ss_decode = {NUM_SS{SS_DISCONNECT}};
        for (int i = 0; i < NUM_SS; i++)
            if (sel == SEL_W'(i)) ss_decode[i] = SS_CONNECT;
    endfunction

    spi_state_e        state_q;
    spi_mode_t         mode_q;
    logic              lsb_q, mosi_q, rx_valid_q, hold_first_q;
    logic [DIV_W-1:0]  div_q;
    logic [SEL_W-1:0]  sel_q;
    logic [NUM_SS-1:0] ss_n_q;
    logic [DATA_W-1:0] rx_data_q, tx_sh_q, rx_sh_q, ord_tx;
    logic              accept, direct, restart, gen_cpol;
    logic              tick, lead, trail, last;
    logic              sample, drive, pop_load, pop_gap;

    assign tx_ready = (state_q == IDLE || state_q == HOLD) ? SPI_READY : ~SPI_READY;
    assign busy     = (state_q != IDLE) ? SPI_BUSY : ~SPI_BUSY;
    assign accept   = tx_valid && (tx_ready == SPI_READY);
    // Internally bits always leave from the MSB end; LSB-first words are mirrored at load.
    assign ord_tx   = cfg_lsb_first ? bitrev(tx_data) : tx_data;
    assign direct   = accept && (state_q == IDLE || tx_ss_sel == sel_q);
    assign restart  = accept || (state_q == GAP && tick);
    assign gen_cpol = accept ? cfg_cpol : mode_q.cpol;
    assign sample   = (state_q == SHIFT) && (mode_q.cpha ? trail : lead);
    assign drive    = (state_q == SHIFT) && (mode_q.cpha ? lead : (trail && !last));
    assign pop_load = direct && !cfg_cpha;
    assign pop_gap  = (state_q == GAP) && tick && !mode_q.cpha;

    spi_clk_gen #(
        .DATA_W   (DATA_W),
        .DIV_W    (DIV_W),
        .CPOL_RST (CPOL_RST)
    ) u_clk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .div_i     (div_q),
        .cpol_i    (gen_cpol),
        .run_i     (state_q != IDLE),
        .restart_i (restart),
        .tick_o    (tick),
        .lead_o    (lead),
        .trail_o   (trail),
        .last_o    (last),
        .sclk_o    (sclk)
    );

    always_ff @(posedge clk) begin
        if (sample) rx_sh_q <= {rx_sh_q[DATA_W-2:0], miso};
        if (accept) tx_sh_q <= pop_load ? (ord_tx << 1) : ord_tx;
        else if (pop_gap || drive) tx_sh_q <= tx_sh_q << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mode_q       <= '{cpol: CPOL_RST, cpha: 1'b0};
            lsb_q        <= 1'b0;
            div_q        <= '0;
            sel_q        <= '0;
            ss_n_q       <= {NUM_SS{SS_DISCONNECT}};
            mosi_q       <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= '0;
            hold_first_q <= 1'b0;
        end else begin
            rx_valid_q   <= 1'b0;
            hold_first_q <= 1'b0;
            if (pop_load) mosi_q <= ord_tx[DATA_W-1];
            else if (pop_gap || drive) mosi_q <= tx_sh_q[DATA_W-1];
            if (hold_first_q) begin
                rx_valid_q <= 1'b1;
                rx_data_q  <= lsb_q ? bitrev(rx_sh_q) : rx_sh_q;
            end
            if (accept) begin
                mode_q <= '{cpol: cfg_cpol, cpha: cfg_cpha};
                lsb_q  <= cfg_lsb_first;
                div_q  <= cfg_clk_div;
                sel_q  <= tx_ss_sel;
            end
            case (state_q)
                IDLE: if (accept) begin
                    state_q <= SETUP;
                    ss_n_q  <= ss_decode(tx_ss_sel);
                end
                SETUP: if (tick) state_q <= SHIFT;
                SHIFT: if (last) begin
                    state_q      <= HOLD;
                    hold_first_q <= 1'b1;
                end
                // Same target keeps ss_n low straight through; a new target goes via GAP.
                HOLD: if (accept) begin
                    state_q <= direct ? SETUP : GAP;
                    ss_n_q  <= direct ? ss_decode(tx_ss_sel) : {NUM_SS{SS_DISCONNECT}};
                end else if (tick) begin
                    state_q <= IDLE;
                    ss_n_q  <= {NUM_SS{SS_DISCONNECT}};
                end
                GAP: if (tick) begin
                    state_q <= SETUP;
                    ss_n_q  <= ss_decode(sel_q);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mosi     = mosi_q;
    assign ss_n     = ss_n_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param (DATA_W=8, NUM_SS=4, DIV_W=8, CPOL_RST=0).
module tb_spi_master_param;

    logic       clk, rst_n;
    logic       cfg_cpol, cfg_cpha, cfg_lsb_first;
    logic [7:0] cfg_clk_div;
    logic       tx_valid, tx_ready;
    logic [7:0] tx_data;
    logic [1:0] tx_ss_sel;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy, sclk, mosi, miso;
    logic [3:0] ss_n;

    logic       loopback, slave_en, miso_s;
    logic [7:0] slave_word;
    int         slave_idx;
    int         errors, checks;

    spi_master_param #(
        .DATA_W(8), .NUM_SS(4), .DIV_W(8), .CPOL_RST(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_lsb_first(cfg_lsb_first),
        .cfg_clk_div(cfg_clk_div),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_ss_sel(tx_ss_sel),
        .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
        .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign miso = loopback ? mosi : miso_s;

    // Slave for CPHA=1 modes: presents the next LSB-first bit on each falling (leading, CPOL=1) edge.
    always @(negedge sclk) begin
        if (slave_en) begin
            miso_s = slave_word[slave_idx];
            slave_idx = slave_idx + 1;
        end else begin
            slave_idx = 0;
        end
    end

    task automatic xfer(input logic [7:0] d, input logic [1:0] sel, input logic cpol, input logic cpha,
                        input logic lsb, input logic [7:0] div, input int flip_at,
                        output logic [7:0] rx, output int cyc, output int rises,
                        output logic [7:0] mbits, output logic pulse2, output logic tmo);
        logic prev;
        cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb_first = lsb; cfg_clk_div = div;
        tx_data = d; tx_ss_sel = sel; tx_valid = 1'b1;
        @(posedge clk); #1 tx_valid = 1'b0;
        prev = sclk; cyc = 0; rises = 0; mbits = '0; rx = '0; pulse2 = 1'bx; tmo = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (cyc == flip_at) cfg_cpol = ~cfg_cpol;
            if (prev === 1'b0 && sclk === 1'b1) begin
                mbits = {mbits[6:0], mosi};
                if (ss_n === ~(4'b0001 << sel)) rises++;
            end
            prev = sclk;
            if (rx_valid === 1'b1) begin
                rx = rx_data; tmo = 1'b0;
                break;
            end
        end
        @(posedge clk); @(negedge clk); pulse2 = rx_valid;
        for (int c = 0; c < 200 && busy !== 1'b0; c++) @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk got=%b exp=0", sclk); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi got=%b exp=0", mosi); end
        checks++; if (ss_n !== 4'b1111) begin errors++; $display("FAIL rst_ss_n got=%b exp=1111", ss_n); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready got=%b exp=1", tx_ready); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data got=%h exp=00", rx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    endtask

    task automatic test_mode0_msb;
        logic [7:0] rx, mb; int cyc, rises; logic p2, tmo;
        loopback = 1'b1;
        xfer(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 8'd1, -1, rx, cyc, rises, mb, p2, tmo);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL m0_timeout got=%b exp=0", tmo); end
        checks++; if (rx !== 8'hA5) begin errors++; $display("FAIL m0_rx_data got=%h exp=a5", rx); end
        checks++; if (cyc != 35) begin errors++; $display("FAIL m0_latency got=%0d exp=35", cyc); end
        checks++; if (rises != 8) begin errors++; $display("FAIL m0_sclk_rises got=%0d exp=8", rises); end
        checks++; if (mb !== 8'hA5) begin errors++; $display("FAIL m0_mosi_bits got=%h exp=a5", mb); end
        checks++; if (p2 !== 1'b0) begin errors++; $display("FAIL m0_rx_valid_width got=%b exp=0", p2); end
    endtask

    task automatic test_mode3_lsb;
        logic [7:0] rx, mb; int cyc, rises; logic p2, tmo;
        loopback = 1'b0; slave_word = 8'h81; slave_en = 1'b1;
        xfer(8'h3C, 2'd1, 1'b1, 1'b1, 1'b1, 8'd0, -1, rx, cyc, rises, mb, p2, tmo);
        slave_en = 1'b0;
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL m3_timeout got=%b exp=0", tmo); end
        checks++; if (mb !== 8'b0011_1100) begin errors++; $display("FAIL m3_mosi_seq got=%b exp=00111100", mb); end
        checks++; if (rx !== 8'h81) begin errors++; $display("FAIL m3_rx_data got=%h exp=81", rx); end
        checks++; if (cyc != 18) begin errors++; $display("FAIL m3_latency got=%0d exp=18", cyc); end
        checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL m3_sclk_idle got=%b exp=1", sclk); end
        checks++; if (ss_n !== 4'b1111) begin errors++; $display("FAIL m3_ss_idle got=%b exp=1111", ss_n); end
    endtask

    task automatic test_back_to_back;
        int pulses, glitch; logic [7:0] got [2];
        loopback = 1'b1; cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0; cfg_clk_div = 8'd1;
        got[0] = '0; got[1] = '0;
        tx_ss_sel = 2'd2; tx_data = 8'h11; tx_valid = 1'b1;
        @(posedge clk); #1 tx_data = 8'h22;
        pulses = 0; glitch = 0;
        for (int c = 0; c < 300 && pulses < 2; c++) begin
            @(negedge clk);
            if (ss_n[2] !== 1'b0) glitch++;
            if (rx_valid === 1'b1) begin got[pulses] = rx_data; pulses++; end
            if (tx_ready === 1'b1 && tx_valid) begin @(posedge clk); #1 tx_valid = 1'b0; end
        end
        tx_valid = 1'b0;
        for (int c = 0; c < 200 && busy !== 1'b0; c++) @(negedge clk);
        checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
        checks++; if (glitch != 0) begin errors++; $display("FAIL b2b_ss_glitch got=%0d exp=0", glitch); end
        checks++; if (got[0] !== 8'h11) begin errors++; $display("FAIL b2b_rx0 got=%h exp=11", got[0]); end
        checks++; if (got[1] !== 8'h22) begin errors++; $display("FAIL b2b_rx1 got=%h exp=22", got[1]); end
    endtask

    task automatic test_gap;
        int pulses, gapc, sel3; logic [7:0] got [2];
        loopback = 1'b1; cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0; cfg_clk_div = 8'd1;
        got[0] = '0; got[1] = '0;
        tx_ss_sel = 2'd1; tx_data = 8'h33; tx_valid = 1'b1;
        @(posedge clk); #1 tx_data = 8'hCC; tx_ss_sel = 2'd3;
        pulses = 0; gapc = 0; sel3 = 0;
        for (int c = 0; c < 300 && pulses < 2; c++) begin
            @(negedge clk);
            if (ss_n === 4'b1111) gapc++;
            if (ss_n === 4'b0111) sel3++;
            if (rx_valid === 1'b1) begin got[pulses] = rx_data; pulses++; end
            if (tx_ready === 1'b1 && tx_valid) begin @(posedge clk); #1 tx_valid = 1'b0; end
        end
        tx_valid = 1'b0;
        for (int c = 0; c < 200 && busy !== 1'b0; c++) @(negedge clk);
        checks++; if (pulses != 2) begin errors++; $display("FAIL gap_pulses got=%0d exp=2", pulses); end
        checks++; if (gapc != 2) begin errors++; $display("FAIL gap_len got=%0d exp=2", gapc); end
        checks++; if (sel3 == 0) begin errors++; $display("FAIL gap_sel3_low got=%0d exp=>0", sel3); end
        checks++; if (got[0] !== 8'h33) begin errors++; $display("FAIL gap_rx0 got=%h exp=33", got[0]); end
        checks++; if (got[1] !== 8'hCC) begin errors++; $display("FAIL gap_rx1 got=%h exp=cc", got[1]); end
    endtask

    task automatic test_reset_mid;
        logic prev; int tog, rv;
        logic [7:0] rx, mb; int cyc, rises; logic p2, tmo;
        loopback = 1'b1; cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0; cfg_clk_div = 8'd1;
        tx_ss_sel = 2'd0; tx_data = 8'hF0; tx_valid = 1'b1;
        @(posedge clk); #1 tx_valid = 1'b0;
        prev = sclk; tog = 0;
        for (int c = 0; c < 100 && tog < 3; c++) begin
            @(negedge clk);
            if (sclk !== prev) tog++;
            prev = sclk;
        end
        rst_n = 1'b0; #1;
        checks++; if (tog != 3) begin errors++; $display("FAIL rmid_edges got=%0d exp=3", tog); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rmid_sclk got=%b exp=0", sclk); end
        checks++; if (ss_n !== 4'b1111) begin errors++; $display("FAIL rmid_ss_n got=%b exp=1111", ss_n); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rmid_tx_ready got=%b exp=1", tx_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        rv = 0;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin @(negedge clk); if (rx_valid !== 1'b0) rv++; end
        checks++; if (rv != 0) begin errors++; $display("FAIL rmid_no_rx_valid got=%0d exp=0", rv); end
        xfer(8'h5A, 2'd0, 1'b0, 1'b0, 1'b0, 8'd1, -1, rx, cyc, rises, mb, p2, tmo);
        checks++; if (rx !== 8'h5A || tmo !== 1'b0) begin errors++; $display("FAIL rmid_after_rx got=%h tmo=%b exp=5a tmo=0", rx, tmo); end
    endtask

    task automatic test_cpol_change;
        logic [7:0] rx, mb; int cyc, rises; logic p2, tmo;
        loopback = 1'b1;
        xfer(8'h96, 2'd3, 1'b0, 1'b0, 1'b0, 8'd2, 12, rx, cyc, rises, mb, p2, tmo);
        checks++; if (rx !== 8'h96 || tmo !== 1'b0) begin errors++; $display("FAIL cpol_rx got=%h tmo=%b exp=96 tmo=0", rx, tmo); end
        checks++; if (rises != 8) begin errors++; $display("FAIL cpol_rises got=%0d exp=8", rises); end
        checks++; if (cyc != 52) begin errors++; $display("FAIL cpol_latency got=%0d exp=52", cyc); end
        repeat (3) @(negedge clk);
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL cpol_idle_old got=%b exp=0", sclk); end
        xfer(8'h69, 2'd3, 1'b1, 1'b0, 1'b0, 8'd1, -1, rx, cyc, rises, mb, p2, tmo);
        checks++; if (rx !== 8'h69 || tmo !== 1'b0) begin errors++; $display("FAIL cpol2_rx got=%h tmo=%b exp=69 tmo=0", rx, tmo); end
        checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL cpol2_idle_new got=%b exp=1", sclk); end
    endtask

    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0; loopback = 1'b1; slave_en = 1'b0; slave_word = '0; miso_s = 1'b0;
        cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_lsb_first = 1'b0; cfg_clk_div = '0;
        tx_valid = 1'b0; tx_data = '0; tx_ss_sel = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_mode0_msb();
        test_mode3_lsb();
        test_back_to_back();
        test_gap();
        test_reset_mid();
        test_cpol_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
